fft_engine: RTL and testbench
=============================

// Module: fft_engine
// PURPOSE
//  In-place radix-2 DIT FFT engine: streams in N complex samples, runs log2(N) butterfly stages, streams out N bins.
//  Owns sample memory, address sequencing, twiddle addressing and one butterfly unit.
//  Sits between the Hann-windowed sample stream and the spectrum consumer; reads twiddles from the external twiddle ROM.
// PARAMETERS
//  WIDTH  16  bits per real/imag part; words are {re,im}, 2*WIDTH bits, signed Q1.(WIDTH-1)
//  N_2    5   log2(points); N = 2**N_2, legal range 2..12
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high
//  start        in   1          begin a frame; honoured only in IDLE
//  in_data      in   2*WIDTH    input sample {re,im}, natural order
//  in_valid     in   1          in_data valid
//  in_ready     out  1          engine accepts in_data
//  twiddleadr   out  N_2-1      twiddle ROM address; ROM returns data one cycle later
//  twiddle      in   2*WIDTH    W_N^k {re,im} from ROM
//  out_data     out  2*WIDTH    spectrum bin {re,im}, natural order (bin 0 first)
//  out_valid    out  1          out_data valid
//  out_ready    in   1          consumer accepts out_data
//  busy         out  1          high in every state except IDLE
//  done         out  1          one-cycle pulse after last bin accepted
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, busy, done, twiddleadr, out_data = 0; counters = 0; memory contents undefined.
//  Reset at any time (mid-LOAD/CALC/UNLOAD) aborts the frame and returns to IDLE next cycle; no done.
//  States: IDLE -> LOAD -> CALC -> UNLOAD -> IDLE.
//  IDLE: start=1 -> LOAD next cycle. start in any other state ignored.
//  LOAD: in_ready=1. On in_valid&&in_ready, write sample n to mem[bitrev(n)], n++. After n=N-1 accepted -> CALC.
//   in_valid low stalls load indefinitely.
//  CALC: for stage s=0..N_2-1, butterfly j=0..N/2-1:
//   span=2**s; adra=((j>>s)<<(s+1))+(j&(span-1)); adrb=adra+span; twiddleadr=(j&(span-1))<<(N_2-1-s).
//   2 cycles per butterfly: cycle0 drive adr/twiddleadr; cycle1 read mem[adra],mem[adrb], twiddle, write results.
//   CALC lasts exactly N_2*N cycles; no stalls. Then -> UNLOAD.
//  Butterfly: t = b*twiddle, each real product is full 2*WIDTH signed then arithmetic >> (WIDTH-1), truncated to WIDTH.
//   t_re = br*wr - bi*wi; t_im = br*wi + bi*wr; aout = a+t; bout = a-t; all WIDTH-bit two's complement, wrap on overflow.
//   Slicing derived from WIDTH throughout (no fixed 16-bit slices).
//  UNLOAD: out_valid=1, out_data=mem[k], k from 0. On out_valid&&out_ready, k++. out_data held stable while out_ready=0.
//   After k=N-1 accepted: out_valid=0, done=1 for one cycle, -> IDLE. start in that done cycle is ignored.
//  in_ready=0 outside LOAD; out_valid=0 outside UNLOAD; twiddleadr held at 0 outside CALC.
//  Latency: start -> in_ready 1 cycle; last input -> first out_valid N_2*N+1 cycles.
// CONFIGURATION
//  FFT_SCALE_EN defined: each stage outputs (a+t)>>>1 and (a-t)>>>1 (arithmetic, floor); total gain 1/N; no overflow
//   for any |input| < 1.0.
//  FFT_SCALE_EN undefined: unscaled; caller leaves N_2 guard bits in in_data; overflow wraps silently.
// TESTING (WIDTH=16, N_2=3 unless noted)
//  Impulse: x[0]=0x4000_0000, others 0 -> all 8 bins 0x4000_0000 (scaled: 0x0800_0000).
//  DC: all x=0x0800_0000 -> bin0=0x4000_0000, bins1..7=0 (scaled: bin0=0x0800_0000), +/-1 LSB allowed on zeros.
//  Tone: x[n]=0x0800*cos(2*pi*n/8) real -> bins 1 and 7 = 0x2000 re (+/-2 LSB), others ~0; repeat N_2=5 vs golden model.
//  Handshake: random in_valid gaps and out_ready low for 3 cycles mid-unload -> out_data stable, order and values unchanged, done after bin 7.
//  Reset mid-CALC -> next cycle busy=0, out_valid=0, no done; following full frame produces correct impulse result.
//  start pulsed during LOAD/CALC/UNLOAD -> ignored; exactly one done per frame; CALC length = 24 cycles.

Source files
------------

// File: rtl/fft_engine.sv
`default_nettype none
// ============================================================================
//  Module   : fft_engine
//  Purpose  : In-place radix-2 decimation-in-time FFT engine. It loads N
//             complex samples into memory in bit-reversed order, runs
//             log2(N) butterfly stages with one shared butterfly unit, then
//             streams the N bins out in natural order.
//  Options  : FFT_SCALE_EN - when defined, every stage halves its outputs
//             (total gain 1/N); when undefined the engine is unscaled.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_engine #(
  parameter int WIDTH = 16,
  parameter int N_2   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N_2-2:0]       twiddleadr,
  input  logic [2*WIDTH-1:0]   twiddle,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int             c_n     = 2**N_2;
  localparam int             c_dw    = 2*WIDTH;
  localparam logic [N_2-1:0] c_n_one = N_2'(1);
  localparam logic [N_2-2:0] c_j_one = (N_2-1)'(1);
  localparam logic [3:0]     c_s_max = 4'(N_2-1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CALC   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  state_t            r_state;
  logic [N_2-1:0]    r_n;          // load sample index
  logic [N_2-1:0]    r_k;          // unload bin index
  logic [N_2-2:0]    r_j;          // butterfly index within stage
  logic [3:0]        r_s;          // stage index
  logic              r_phase;      // 0: address cycle, 1: compute/write cycle
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic [N_2-2:0]    r_twiddleadr;
  logic [c_dw-1:0]   r_out_data;
  logic [c_dw-1:0]   r_mem [c_n];

  logic [N_2-1:0]    w_jx, w_mask, w_adra, w_adrb;
  logic [c_dw-1:0]   w_a, w_b;
  logic signed [WIDTH-1:0] w_ar, w_ai, w_br, w_bi, w_wr, w_wi;
  logic signed [WIDTH-1:0] w_tr, w_ti, w_aor, w_aoi, w_bor, w_boi;
  logic              w_last_j, w_last_s;

  function automatic logic [N_2-1:0] f_bitrev(input logic [N_2-1:0] v);
    logic [N_2-1:0] r;
    for (int i = 0; i < N_2; i++) r[i] = v[N_2-1-i];
    return r;
  endfunction

  // Twiddle index for butterfly j of stage s: (j mod span) scaled up to N/2.
  function automatic logic [N_2-2:0] f_twid(input logic [N_2-2:0] j, input logic [3:0] s);
    logic [N_2-2:0] mask;
    mask = (c_j_one << s) - c_j_one;
    return (j & mask) << (c_s_max - s);
  endfunction

  // Q1.(WIDTH-1) product: full-width signed multiply, arithmetic shift, truncate.
  function automatic logic signed [WIDTH-1:0] f_mulq(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
    return WIDTH'((c_dw'(a) * c_dw'(b)) >>> (WIDTH-1));
  endfunction

  // Butterfly operand addresses and the combinational butterfly datapath.
  always_comb begin
    w_jx     = {1'b0, r_j};
    w_mask   = (c_n_one << r_s) - c_n_one;
    w_adra   = ((w_jx >> r_s) << (r_s + 4'd1)) + (w_jx & w_mask);
    w_adrb   = w_adra + (c_n_one << r_s);
    w_last_j = &r_j;
    w_last_s = (r_s == c_s_max);
    w_a  = r_mem[w_adra];
    w_b  = r_mem[w_adrb];
    w_ar = w_a[c_dw-1:WIDTH];
    w_ai = w_a[WIDTH-1:0];
    w_br = w_b[c_dw-1:WIDTH];
    w_bi = w_b[WIDTH-1:0];
    w_wr = twiddle[c_dw-1:WIDTH];
    w_wi = twiddle[WIDTH-1:0];
    w_tr = f_mulq(w_br, w_wr) - f_mulq(w_bi, w_wi);
    w_ti = f_mulq(w_br, w_wi) + f_mulq(w_bi, w_wr);
`ifdef FFT_SCALE_EN
    // One guard bit so the halved sum never overflows.
    w_aor = WIDTH'(({w_ar[WIDTH-1], w_ar} + {w_tr[WIDTH-1], w_tr}) >> 1);
    w_aoi = WIDTH'(({w_ai[WIDTH-1], w_ai} + {w_ti[WIDTH-1], w_ti}) >> 1);
    w_bor = WIDTH'(({w_ar[WIDTH-1], w_ar} - {w_tr[WIDTH-1], w_tr}) >> 1);
    w_boi = WIDTH'(({w_ai[WIDTH-1], w_ai} - {w_ti[WIDTH-1], w_ti}) >> 1);
`else
    w_aor = w_ar + w_tr;
    w_aoi = w_ai + w_ti;
    w_bor = w_ar - w_tr;
    w_boi = w_ai - w_ti;
`endif
  end

  // Sample memory: bit-reversed load writes, then in-place butterfly writes.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && in_valid && r_in_ready) begin
      r_mem[f_bitrev(r_n)] <= in_data;
    end else if (r_state == ST_CALC && r_phase) begin
      r_mem[w_adra] <= {w_aor, w_aoi};
      r_mem[w_adrb] <= {w_bor, w_boi};
    end
  end

  // Frame sequencer with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_n          <= '0;
      r_k          <= '0;
      r_j          <= '0;
      r_s          <= '0;
      r_phase      <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_twiddleadr <= '0;
      r_out_data   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // start coinciding with the done pulse belongs to the old frame
          if (start && !r_done) begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_n        <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid && r_in_ready) begin
            r_n <= r_n + c_n_one;
            if (&r_n) begin
              r_state      <= ST_CALC;
              r_in_ready   <= 1'b0;
              r_j          <= '0;
              r_s          <= '0;
              r_phase      <= 1'b0;
              r_twiddleadr <= '0;
            end
          end
        end
        ST_CALC: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            if (w_last_j) begin
              r_j          <= '0;
              r_twiddleadr <= '0;
              if (w_last_s) begin
                // mem[0] is never touched by the final butterfly (N >= 4),
                // so reading it here sees the finished value.
                r_state     <= ST_UNLOAD;
                r_s         <= '0;
                r_k         <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[0];
              end else begin
                r_s <= r_s + 4'd1;
              end
            end else begin
              r_j          <= r_j + c_j_one;
              r_twiddleadr <= f_twid(r_j + c_j_one, r_s);
            end
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (&r_k) begin
              r_state     <= ST_IDLE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_k        <= r_k + c_n_one;
              r_out_data <= r_mem[r_k + c_n_one];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign twiddleadr = r_twiddleadr;

endmodule
`default_nettype wire

// File: tb/tb_fft_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_engine
//  Purpose  : Scoreboard bench for fft_engine (WIDTH=16, N_2=3). Expected
//             bins come from constants or a textbook iterative FFT model
//             using the same fixed-point butterfly rules.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_engine;

  localparam int WIDTH = 16;
  localparam int N_2   = 3;
  localparam int N     = 8;

  typedef logic [31:0] frame_t [N];
  typedef struct packed { logic [31:0] exp; logic [7:0] idx; } sb_t;

  logic              clk = 1'b0;
  logic              reset, start, in_valid, out_ready;
  logic [31:0]       in_data, twiddle, out_data;
  logic              in_ready, out_valid, busy, done;
  logic [N_2-2:0]    twiddleadr;

  int     n_tests = 0;
  int     n_fail  = 0;
  sb_t    sb_q[$];
  int     rom_re[N/2], rom_im[N/2];
  logic [31:0] rom[N/2];

  fft_engine #(.WIDTH(WIDTH), .N_2(N_2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .twiddleadr(twiddleadr), .twiddle(twiddle),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered twiddle ROM: data one cycle after address.
  always @(posedge clk) twiddle <= rom[twiddleadr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rnd(real r);
    int v;
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic int w16(int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int mulq(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return w16(int'(p >>> 15));
  endfunction

  function automatic int brev(int v);
    int r = 0;
    for (int i = 0; i < N_2; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Iterative DIT FFT over groups of size m with twiddle W_N^(j*N/m).
  task automatic fft_model(input frame_t x, output frame_t y);
    int re[N], im[N];
    int k, ia, ib, tr, ti, ar, ai;
    logic [31:0] xv;
    for (int n = 0; n < N; n++) begin
      xv = x[n];
      re[brev(n)] = w16(int'(xv[31:16]));
      im[brev(n)] = w16(int'(xv[15:0]));
    end
    for (int m = 2; m <= N; m = m * 2)
      for (int base = 0; base < N; base += m)
        for (int j = 0; j < m/2; j++) begin
          k  = j * (N / m);
          ia = base + j;
          ib = ia + m/2;
          tr = w16(mulq(re[ib], rom_re[k]) - mulq(im[ib], rom_im[k]));
          ti = w16(mulq(re[ib], rom_im[k]) + mulq(im[ib], rom_re[k]));
          ar = re[ia];
          ai = im[ia];
          re[ia] = w16(ar + tr); im[ia] = w16(ai + ti);
          re[ib] = w16(ar - tr); im[ib] = w16(ai - ti);
        end
    for (int n = 0; n < N; n++) y[n] = {re[n][15:0], im[n][15:0]};
  endtask

  // Monitor: pops expected bins on each accepted output, checks hold stability.
  initial begin
    bit          hold;
    logic [31:0] hd;
    sb_t         e;
    hold = 1'b0;
    hd   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) check("hold_stable", {out_valid, out_data}, {1'b1, hd});
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h, expected none", out_data);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("bin%0d", e.idx), out_data, e.exp);
          end
        end
        hold = out_valid && !out_ready;
        hd   = out_data;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("in_ready_after_start", {busy, in_ready}, 2'b11);
  endtask

  task automatic load_frame(input frame_t x, input bit gaps, input bit noise, output bit ok);
    int cnt;
    ok = 1'b1;
    for (int n = 0; n < N; n++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin in_valid = 1'b0; @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = x[n];
      if (noise && n == 3) start = 1'b1;
      cnt = 0;
      while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
      if (cnt >= 20) begin
        check("load_timeout", 1, 0);
        in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // rdy_mode: 0 always ready, 1 three-cycle stall mid-unload, 2 random.
  task automatic run_frame(input frame_t x, input frame_t y, input bit gaps,
                           input int rdy_mode, input bit noise);
    int cnt, cyc, dones;
    bit ok;
    for (int n = 0; n < N; n++) sb_q.push_back('{exp: y[n], idx: 8'(n)});
    start_frame();
    load_frame(x, gaps, noise, ok);
    if (!ok) return;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      if (noise) start = (cnt == 5);
      if (cnt == 10) check("busy_in_calc", {busy, in_ready, out_valid}, 3'b100);
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    check("calc_cycles", cnt, N_2 * N);
    dones = 0;
    cyc   = 0;
    while (cyc < 200) begin
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 3 && cyc < 6);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (noise) start = (cyc == 2);
      @(negedge clk);
      if (done) begin dones++; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check("out_valid_low_at_done", {out_valid, busy}, 2'b00);
    start = 1'b1;
    @(posedge clk); #1;
    check("start_in_done_ignored", {busy, in_ready}, 2'b00);
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (4) begin @(negedge clk); if (done) dones++; end
    check("done_count", dones, 1);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic reset_mid_calc(input frame_t x);
    int bad;
    bit ok;
    start_frame();
    load_frame(x, 1'b0, 1'b0, ok);
    if (!ok) return;
    repeat (10) begin @(posedge clk); #1; end
    check("busy_before_abort", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_state", {busy, out_valid, done, in_ready, twiddleadr}, '0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (out_valid || done || busy) bad++; end
    check("abort_quiet", bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    frame_t x, y;
    real    pi;
    pi = 3.14159265358979;
    for (int k = 0; k < N/2; k++) begin
      rom_re[k] = rnd($cos(2.0 * pi * k / N) * 32768.0);
      rom_im[k] = rnd(-$sin(2.0 * pi * k / N) * 32768.0);
      rom[k]    = {16'(rom_re[k]), 16'(rom_im[k])};
    end
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, busy, done, twiddleadr, out_data}, '0);
    reset = 1'b0;

    // Impulse: every bin equals the impulse value.
    for (int n = 0; n < N; n++) begin x[n] = '0; y[n] = 32'h4000_0000; end
    x[0] = 32'h4000_0000;
    run_frame(x, y, 1'b0, 0, 1'b0);

    // DC input.
    for (int n = 0; n < N; n++) x[n] = 32'h0800_0000;
    fft_model(x, y);
    run_frame(x, y, 1'b1, 0, 1'b0);

    // Real cosine tone at bin 1, with a mid-unload stall.
    for (int n = 0; n < N; n++) x[n] = {16'(rnd(2048.0 * $cos(2.0 * pi * n / N))), 16'h0000};
    fft_model(x, y);
    run_frame(x, y, 1'b1, 1, 1'b1);

    // Random frames with random handshakes and stray start pulses.
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < N; n++) x[n] = $urandom;
      fft_model(x, y);
      run_frame(x, y, 1'b1, 2, 1'b1);
    end

    // Abort mid-CALC, then a clean impulse frame.
    for (int n = 0; n < N; n++) x[n] = $urandom;
    reset_mid_calc(x);
    for (int n = 0; n < N; n++) begin x[n] = '0; y[n] = 32'h4000_0000; end
    x[0] = 32'h4000_0000;
    run_frame(x, y, 1'b1, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
